// File: rtl/template_capture_if.sv
// Pixel-stream, capture-control and template-read signals of template_capture.
// Signal names are kept identical to the original flat port list.
interface template_capture_if;
  logic [12:0] iX;
  logic [12:0] iY;
  logic        iDVAL;
  logic [9:0]  iDATA;
  logic [9:0]  iTHRESH;
  logic        iSTART;
  logic        oBUSY;
  logic        oDONE;
  logic [7:0]  iRD_ADDR;
  logic [9:0]  oRD_DATA;

  // Pixel source / controller side
  modport master (
    output iX, iY, iDVAL, iDATA, iTHRESH, iSTART, iRD_ADDR,
    input  oBUSY, oDONE, oRD_DATA
  );

  // Template capture block side
  modport slave (
    input  iX, iY, iDVAL, iDATA, iTHRESH, iSTART, iRD_ADDR,
    output oBUSY, oDONE, oRD_DATA
  );
endinterface

// File: rtl/template_capture.sv
// Captures a 16x16 binary template from a raster pixel stream. Each cell is
// 2^HALVING pixels square; the cell average is thresholded against iTHRESH on
// the cell's last pixel and stored as one bit (white/black) in a 256-entry map.
module template_capture #(
  parameter int unsigned HALVING = 3
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  template_capture_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_e;

  localparam int unsigned CELL      = 1 << HALVING;
  localparam int unsigned AVG_SHIFT = 2 * HALVING;
  localparam logic [12:0] WIN_LIMIT = 13'(16 * CELL);
  localparam logic [12:0] LOW_MASK  = 13'(CELL - 1);

  state_e      state_q, state_d;
  logic [15:0] acc_q [16];
  logic [15:0] acc_d [16];
  logic [255:0] tmpl_q, tmpl_d;
  logic        rd_q, rd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        in_window;
  logic        at_origin;
  logic        cell_last;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [7:0]  cell_addr;
  logic        accept;
  logic        restart;
  logic        wr_en;
  logic [15:0] sum;
  logic [15:0] avg;
  logic        white;

  // Pixel qualification, cell addressing and the threshold decision
  always_comb begin
    in_window = (bus.iX < WIN_LIMIT) && (bus.iY < WIN_LIMIT);
    at_origin = (bus.iX == '0) && (bus.iY == '0);
    cell_last = ((bus.iX & LOW_MASK) == LOW_MASK) && ((bus.iY & LOW_MASK) == LOW_MASK);
    col       = 4'(bus.iX >> HALVING);
    row       = 4'(bus.iY >> HALVING);
    cell_addr = {row, col};
    // The (0,0) pixel that arms the capture is accumulated exactly like a
    // restart pixel during CAPTURE, so both paths share 'restart'.
    accept    = bus.iDVAL && in_window &&
                ((state_q == S_CAPTURE) || ((state_q == S_ARMED) && at_origin));
    restart   = accept && at_origin;
    wr_en     = accept && cell_last;
    sum       = (restart ? 16'd0 : acc_q[col]) + {6'd0, bus.iDATA};
    avg       = sum >> AVG_SHIFT;
    white     = (avg >= {6'd0, bus.iTHRESH});
  end

  // Next-state, accumulator, template and output-register computation
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (bus.iSTART) state_d = S_ARMED;
      S_ARMED:   if (restart) state_d = S_CAPTURE;
      S_CAPTURE: if (wr_en && (cell_addr == 8'hFF)) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    for (int unsigned i = 0; i < 16; i++) begin
      acc_d[i] = restart ? 16'd0 : acc_q[i];
    end
    if (accept) begin
      acc_d[col] = cell_last ? 16'd0 : sum;
    end

    tmpl_d = tmpl_q;
    if (wr_en) begin
      tmpl_d[cell_addr] = white;
    end

    // Reads the pre-write contents, so a same-cycle write returns old data
    rd_d   = tmpl_q[bus.iRD_ADDR];
    busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  // All state, with async active-low reset; template resets to all white
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_IDLE;
      for (int unsigned i = 0; i < 16; i++) begin
        acc_q[i] <= '0;
      end
      tmpl_q <= '1;
      rd_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int unsigned i = 0; i < 16; i++) begin
        acc_q[i] <= acc_d[i];
      end
      tmpl_q <= tmpl_d;
      rd_q   <= rd_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.oBUSY    = busy_q;
  assign bus.oDONE    = done_q;
  assign bus.oRD_DATA = rd_q ? 10'd255 : 10'd0;

endmodule

// File: doc/template_capture.md
TEMPLATE_CAPTURE -- requirements
Module: template_capture

Interface
REQ-001 The block SHALL have one clock, iCLK; reset SHALL be asynchronous and active-low, iRST_N.
REQ-002 Parameter HALVING, default 3, SHALL set the cell size as 2^HALVING pixels square; the grid SHALL be fixed at 16x16 cells.
REQ-003 Port iCLK, input, 1, SHALL be the pixel clock.
REQ-004 Port iRST_N, input, 1, SHALL be the async active-low reset.
REQ-005 Port iX, input, 13, SHALL be the current pixel column.
REQ-006 Port iY, input, 13, SHALL be the current pixel row.
REQ-007 Port iDVAL, input, 1, SHALL qualify iX/iY/iDATA.
REQ-008 Port iDATA, input, 10, SHALL be the grayscale pixel value.
REQ-009 Port iTHRESH, input, 10, SHALL be the binarisation threshold, sampled per cell write.
REQ-010 Port iSTART, input, 1, SHALL be a one-cycle capture request.
REQ-011 Port oBUSY, output, 1, SHALL be high in ARMED and CAPTURE.
REQ-012 Port oDONE, output, 1, SHALL be a one-cycle completion pulse.
REQ-013 Port iRD_ADDR, input, 8, SHALL be the template read address: row*16 + column.
REQ-014 Port oRD_DATA, output, 10, SHALL be the stored cell: 10'd255 (white) or 10'd0 (black).

Function
REQ-015 The capture window SHALL be iX < 16*2^HALVING and iY < 16*2^HALVING; pixels outside it, or with iDVAL low, SHALL be ignored.
REQ-016 States SHALL be IDLE, ARMED, CAPTURE, DONE.
REQ-017 IDLE -> ARMED on iSTART; iSTART in any other state SHALL be ignored.
REQ-018 ARMED -> CAPTURE on a valid pixel with iX==0 and iY==0; that pixel SHALL be accumulated.
REQ-019 CAPTURE -> DONE on the cycle after cell 255 is written; DONE -> IDLE unconditionally after one cycle; oDONE high only in DONE.
REQ-020 There SHALL be 16 column accumulators, 16 bits each, indexed by iX >> HALVING; each valid in-window pixel in CAPTURE SHALL add iDATA to its accumulator.
REQ-021 The last pixel of a cell is the one with all low HALVING bits of iX and iY set. On that pixel, the cell average SHALL be computed as (acc + iDATA) >> (2*HALVING), with the pixel itself included.
REQ-022 On that same last pixel, the average SHALL be compared with iTHRESH: average >= iTHRESH stores white, otherwise black.
REQ-023 On that same last pixel, the store SHALL go to address (iY>>HALVING)*16 + (iX>>HALVING).
REQ-024 On that same last pixel, the accumulator SHALL be cleared.
REQ-025 The store SHALL take effect on the next rising edge, one cycle after the last pixel is presented.
REQ-026 A valid (0,0) pixel during CAPTURE SHALL restart capture: all accumulators are cleared, then (0,0) is accumulated. Previously written cells SHALL keep their values until overwritten.
REQ-027 On entry to CAPTURE, all accumulators SHALL be cleared.
REQ-028 Template storage SHALL be 256 x 1 bit; oRD_DATA SHALL be registered and valid one cycle after iRD_ADDR.
REQ-029 A read of the address being written in the same cycle SHALL return the old value.
REQ-030 The template SHALL be readable in every state; cells not yet rewritten SHALL return their previous value.
REQ-031 Accumulator sums SHALL not overflow for HALVING <= 3 (64 x 1023 = 65472).

Reset
REQ-032 On iRST_N low, state SHALL go to IDLE and all accumulators to 0.
REQ-033 On iRST_N low, every template cell SHALL go to white, so oRD_DATA reads 10'd255.
REQ-034 On iRST_N low, oBUSY, oDONE and oRD_DATA SHALL go to 0.
REQ-035 Reset asserted mid-CAPTURE SHALL abort the capture with no oDONE.

Verification
REQ-036 Reset, then read addresses 0..255 -> every read returns 10'd255 one cycle after its address.
REQ-037 iSTART, then a full 128x128 frame with iDATA=100 and iTHRESH=512 -> oDONE pulses once, one cycle after cell 255 is written, and all 256 cells read 10'd0.
REQ-038 Frame with iDATA=1023 inside cell (3,4) only, 0 elsewhere, iTHRESH=512 -> address 67 reads 10'd255 and all other addresses read 10'd0.
REQ-039 Cell 0 with 32 pixels at 1023 and 32 at 0 (average 511): iTHRESH=511 -> address 0 reads white; iTHRESH=512 -> address 0 reads black.
REQ-040 A new (0,0) pixel mid-frame during CAPTURE -> no oDONE and accumulators cleared; the following complete frame produces exactly one oDONE with correct cells.
REQ-041 iRST_N low mid-CAPTURE -> oBUSY=0 and no oDONE; a subsequent iSTART with a full frame completes normally.
